// File: rtl/cfg_pkt_pkg.sv
// Shared definitions for the leaf configure/credit packet protocol.
// Field offsets here are also used by the receive-side decoder.
package cfg_pkt_pkg;

    localparam int PACKET_BITS        = 97;
    localparam int NUM_LEAF_BITS      = 6;
    localparam int NUM_PORT_BITS      = 4;
    localparam int NUM_ADDR_BITS      = 7;
    localparam int NUM_BRAM_ADDR_BITS = 7;
    localparam int PAYLOAD_BITS       = 64;

    localparam logic [NUM_PORT_BITS-1:0] PORT_FIELD_OUT = 4'd0;
    localparam logic [NUM_PORT_BITS-1:0] PORT_FIELD_IN  = 4'd1;
    localparam logic [NUM_PORT_BITS-1:0] IN_PORT_MIN    = 4'd2;
    localparam logic [NUM_PORT_BITS-1:0] IN_PORT_MAX    = 4'd8;
    localparam logic [NUM_PORT_BITS-1:0] OUT_PORT_MIN   = 4'd9;
    localparam logic [NUM_PORT_BITS-1:0] OUT_PORT_MAX   = 4'd15;

    typedef enum logic [1:0] {
        CMD_OUT_BIND = 2'd0,
        CMD_IN_BIND  = 2'd1,
        CMD_CREDIT   = 2'd2,
        CMD_RSVD     = 2'd3
    } cmd_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_e;

    // Packet header layout (LSB positions), MSB is the valid bit.
    localparam int PKT_VALID_BIT    = PACKET_BITS - 1;
    localparam int PKT_LEAF_LSB     = PKT_VALID_BIT - NUM_LEAF_BITS;
    localparam int PKT_PORT_LSB     = PKT_LEAF_LSB - NUM_PORT_BITS;
    // Bind payload layout, packed from payload MSB downward.
    localparam int PL_SELF_LSB      = PAYLOAD_BITS - NUM_PORT_BITS;
    localparam int PL_PEER_LEAF_LSB = PL_SELF_LSB - NUM_LEAF_BITS;
    localparam int PL_PEER_PORT_LSB = PL_PEER_LEAF_LSB - NUM_PORT_BITS;
    localparam int PL_BRAM_LSB      = PL_PEER_PORT_LSB - NUM_ADDR_BITS;
    localparam int PL_FREE_LSB      = PL_BRAM_LSB - NUM_BRAM_ADDR_BITS;

    typedef struct packed {
        cmd_type_e                       ctype;
        logic [NUM_LEAF_BITS-1:0]        leaf;
        logic [NUM_PORT_BITS-1:0]        self_port;
        logic [NUM_LEAF_BITS-1:0]        peer_leaf;
        logic [NUM_PORT_BITS-1:0]        peer_port;
        logic [NUM_ADDR_BITS-1:0]        bram_addr;
        logic [NUM_BRAM_ADDR_BITS-1:0]   freespace;
    } cfg_cmd_t;

    function automatic logic cmd_legal(cmd_type_e t, logic [NUM_PORT_BITS-1:0] p);
        case (t)
            CMD_OUT_BIND, CMD_CREDIT: return (p >= OUT_PORT_MIN) && (p <= OUT_PORT_MAX);
            CMD_IN_BIND:              return (p >= IN_PORT_MIN) && (p <= IN_PORT_MAX);
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cfg_cmd_fifo.sv
// Small synchronous command FIFO with full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module cfg_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW:0]                 wr_ptr, rd_ptr;
    logic                        do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cfg_packet_tx.sv
// Configure/credit packet transmitter: buffers commands, checks legality,
// formats packets and emits them with a valid/ready handshake and optional pacing.
module cfg_packet_tx
    import cfg_pkt_pkg::*;
#(
    parameter int PACKET_BITS        = cfg_pkt_pkg::PACKET_BITS,
    parameter int NUM_LEAF_BITS      = cfg_pkt_pkg::NUM_LEAF_BITS,
    parameter int NUM_PORT_BITS      = cfg_pkt_pkg::NUM_PORT_BITS,
    parameter int NUM_ADDR_BITS      = cfg_pkt_pkg::NUM_ADDR_BITS,
    parameter int NUM_BRAM_ADDR_BITS = cfg_pkt_pkg::NUM_BRAM_ADDR_BITS,
    parameter int PAYLOAD_BITS       = cfg_pkt_pkg::PAYLOAD_BITS,
    parameter int FIFO_DEPTH         = 4,
    parameter int MIN_GAP            = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_type,
    input  logic [NUM_LEAF_BITS-1:0]      cmd_leaf,
    input  logic [NUM_PORT_BITS-1:0]      cmd_self_port,
    input  logic [NUM_LEAF_BITS-1:0]      cmd_peer_leaf,
    input  logic [NUM_PORT_BITS-1:0]      cmd_peer_port,
    input  logic [NUM_ADDR_BITS-1:0]      cmd_bram_addr,
    input  logic [NUM_BRAM_ADDR_BITS-1:0] cmd_freespace,
    output logic [PACKET_BITS-1:0]        configure_out,
    input  logic                          out_ready,
    output logic                          err_illegal,
    output logic [15:0]                   pkt_count
);
    localparam logic [3:0] GAP_LOAD = 4'(MIN_GAP > 0 ? MIN_GAP - 1 : 0);

    logic [1:0]             rst_sync;
    logic                   rst_n_i;
    cfg_cmd_t               cmd_in, fifo_rdata;
    logic                   cmd_acc, cmd_ok, fifo_full, fifo_empty, pop;
    logic                   load, clr, cnt_inc;
    tx_state_e              state_q, state_d;
    logic [3:0]             gap_q, gap_d;
    logic [PACKET_BITS-1:0] out_q;
    logic                   err_q;
    logic [15:0]            cnt_q;

    // Reset asserts asynchronously everywhere but releases on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_i = rst_sync[1];

    assign cmd_in = '{ctype:     cmd_type_e'(cmd_type),
                      leaf:      cmd_leaf,
                      self_port: cmd_self_port,
                      peer_leaf: cmd_peer_leaf,
                      peer_port: cmd_peer_port,
                      bram_addr: cmd_bram_addr,
                      freespace: cmd_freespace};

    assign cmd_ready = rst_n_i && !fifo_full;
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign cmd_ok    = cmd_legal(cmd_in.ctype, cmd_in.self_port);

    cfg_cmd_fifo #(
        .WIDTH ($bits(cfg_cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n_i),
        .push  (cmd_acc && cmd_ok),
        .wdata (cmd_in),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    function automatic logic [PACKET_BITS-1:0] build_pkt(cfg_cmd_t c);
        logic [PACKET_BITS-1:0]   p;
        logic [PAYLOAD_BITS-1:0]  pl;
        logic [NUM_PORT_BITS-1:0] port;
        p    = '0;
        pl   = '0;
        port = c.self_port;
        if (c.ctype == CMD_CREDIT) begin
            pl[0] = 1'b1;
        end else begin
            port = (c.ctype == CMD_IN_BIND) ? PORT_FIELD_IN : PORT_FIELD_OUT;
            pl[PL_SELF_LSB      +: NUM_PORT_BITS] = c.self_port;
            pl[PL_PEER_LEAF_LSB +: NUM_LEAF_BITS] = c.peer_leaf;
            pl[PL_PEER_PORT_LSB +: NUM_PORT_BITS] = c.peer_port;
            if (c.ctype == CMD_OUT_BIND) begin
                pl[PL_BRAM_LSB +: NUM_ADDR_BITS]      = c.bram_addr;
                pl[PL_FREE_LSB +: NUM_BRAM_ADDR_BITS] = c.freespace;
            end
        end
        p[PKT_VALID_BIT]                  = 1'b1;
        p[PKT_LEAF_LSB +: NUM_LEAF_BITS]  = c.leaf;
        p[PKT_PORT_LSB +: NUM_PORT_BITS]  = port;
        p[PAYLOAD_BITS-1:0]               = pl;
        return p;
    endfunction

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            err_q   <= cmd_acc && !cmd_ok;
            if (cnt_inc) cnt_q <= cnt_q + 16'd1;
            if (load)     out_q <= build_pkt(fifo_rdata);
            else if (clr) out_q <= '0;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pop     = 1'b0;
        load    = 1'b0;
        clr     = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    cnt_inc = 1'b1;
                    if (MIN_GAP > 0) begin
                        clr     = 1'b1;
                        gap_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end else if (!fifo_empty) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        clr     = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                // Leaving the gap straight into SEND keeps the idle run at exactly MIN_GAP.
                if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign configure_out = out_q;
    assign err_illegal   = err_q;
    assign pkt_count     = cnt_q;

endmodule

// File: tb/tb_cfg_packet_tx.sv
// Randomized bench for cfg_packet_tx against a field-level packet model and an
// in-order scoreboard; a second instance with MIN_GAP=2 shares the stimulus.
module tb_cfg_packet_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_type = '0;
    logic [5:0]  cmd_leaf = '0, cmd_peer_leaf = '0;
    logic [3:0]  cmd_self_port = '0, cmd_peer_port = '0;
    logic [6:0]  cmd_bram_addr = '0, cmd_freespace = '0;
    logic        out_ready = 1'b0;

    logic        cmd_ready, err_illegal, g_cmd_ready, g_err_illegal;
    logic [96:0] configure_out, g_configure_out;
    logic [15:0] pkt_count, g_pkt_count;

    always #5 clk = ~clk;

    cfg_packet_tx #(.MIN_GAP(0)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_leaf(cmd_leaf), .cmd_self_port(cmd_self_port),
        .cmd_peer_leaf(cmd_peer_leaf), .cmd_peer_port(cmd_peer_port),
        .cmd_bram_addr(cmd_bram_addr), .cmd_freespace(cmd_freespace),
        .configure_out(configure_out), .out_ready(out_ready),
        .err_illegal(err_illegal), .pkt_count(pkt_count));

    cfg_packet_tx #(.MIN_GAP(2)) dut_gap (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(g_cmd_ready),
        .cmd_type(cmd_type), .cmd_leaf(cmd_leaf), .cmd_self_port(cmd_self_port),
        .cmd_peer_leaf(cmd_peer_leaf), .cmd_peer_port(cmd_peer_port),
        .cmd_bram_addr(cmd_bram_addr), .cmd_freespace(cmd_freespace),
        .configure_out(g_configure_out), .out_ready(out_ready),
        .err_illegal(g_err_illegal), .pkt_count(g_pkt_count));

    int errors = 0, checks = 0;
    int cyc = 0;
    int err_seen = 0, exp_err = 0, exp_pkts = 0;
    logic [96:0] exp_q[$], obs_q[$], g_obs_q[$];
    int          obs_cyc[$], g_obs_cyc[$];

    always @(posedge clk) cyc++;

    // Passive logging of every handshaked packet and every error-pulse cycle.
    always @(negedge clk) begin
        if (configure_out[96] && out_ready) begin
            obs_q.push_back(configure_out);
            obs_cyc.push_back(cyc);
        end
        if (g_configure_out[96] && out_ready) begin
            g_obs_q.push_back(g_configure_out);
            g_obs_cyc.push_back(cyc);
        end
        if (err_illegal) err_seen++;
    end

    function automatic bit model_legal(int t, int self);
        if (t == 1) return (self >= 2) && (self <= 8);
        if (t == 0 || t == 2) return (self >= 9) && (self <= 15);
        return 1'b0;
    endfunction

    function automatic logic [96:0] model_pkt(int t, int leaf, int self, int pl, int pp,
                                              int ba, int fs);
        logic [63:0] payload;
        logic [96:0] p;
        int          port;
        if (t == 0) begin
            payload = (64'(self) << 60) | (64'(pl) << 54) | (64'(pp) << 50)
                    | (64'(ba) << 43) | (64'(fs) << 36);
            port = 0;
        end else if (t == 1) begin
            payload = (64'(self) << 60) | (64'(pl) << 54) | (64'(pp) << 50);
            port = 1;
        end else begin
            payload = 64'd1;
            port = self;
        end
        p = (97'd1 << 96) | (97'(leaf) << 90) | (97'(port) << 86) | 97'(payload);
        return p;
    endfunction

    task automatic gen_cmd(input bit legal_only, output int t, output int leaf, output int self,
                           output int pl, output int pp, output int ba, output int fs);
        if (legal_only) begin
            t    = $urandom_range(0, 2);
            self = (t == 1) ? $urandom_range(2, 8) : $urandom_range(9, 15);
        end else begin
            t    = $urandom_range(0, 3);
            self = $urandom_range(0, 15);
        end
        leaf = $urandom_range(0, 63);
        pl   = $urandom_range(0, 63);
        pp   = $urandom_range(0, 15);
        ba   = $urandom_range(0, 127);
        fs   = $urandom_range(0, 127);
    endtask

    // Offers one command and returns once it is handshaked (ok=0 on timeout).
    task automatic send_cmd(input int t, input int leaf, input int self, input int pl,
                            input int pp, input int ba, input int fs, output bit ok);
        bit r;
        cmd_valid = 1'b1;
        cmd_type = t[1:0]; cmd_leaf = leaf[5:0]; cmd_self_port = self[3:0];
        cmd_peer_leaf = pl[5:0]; cmd_peer_port = pp[3:0];
        cmd_bram_addr = ba[6:0]; cmd_freespace = fs[6:0];
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            r = cmd_ready;
            @(posedge clk);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (ok) begin
            if (model_legal(t, self)) begin
                exp_q.push_back(model_pkt(t, leaf, self, pl, pp, ba, fs));
                exp_pkts++;
            end else begin
                exp_err++;
            end
        end
    endtask

    task automatic wait_drain(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (obs_q.size() >= exp_q.size()) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        exp_q.delete(); obs_q.delete(); g_obs_q.delete();
        obs_cyc.delete(); g_obs_cyc.delete();
        err_seen = 0; exp_err = 0; exp_pkts = 0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (configure_out !== 97'd0) begin errors++; $display("FAIL reset_out: got %h want 0", configure_out); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
        checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_illegal); end
        checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", pkt_count); end
        do_reset();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", cmd_ready); end
        checks++; if (configure_out !== 97'd0) begin errors++; $display("FAIL post_reset_out: got %h want 0", configure_out); end
    endtask

    task automatic test_out_bind_latency();
        bit ok;
        logic [96:0] want;
        do_reset();
        out_ready = 1'b1;
        want = model_pkt(0, 5, 9, 3, 2, 'h10, 'h7F);
        send_cmd(0, 5, 9, 3, 2, 'h10, 'h7F, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bind_accept: got timeout want handshake"); end
        @(negedge clk);
        checks++; if (configure_out !== 97'd0) begin errors++; $display("FAIL bind_early: got %h want 0", configure_out); end
        @(negedge clk);
        checks++; if (configure_out !== want) begin errors++; $display("FAIL bind_pkt: got %h want %h", configure_out, want); end
        @(negedge clk);
        checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL bind_cnt: got %0d want 1", pkt_count); end
        checks++; if (configure_out !== 97'd0) begin errors++; $display("FAIL bind_clear: got %h want 0", configure_out); end
    endtask

    task automatic test_kinds_stream();
        bit ok, to;
        int t, leaf, self, pl, pp, ba, fs;
        do_reset();
        out_ready = 1'b1;
        send_cmd(1, $urandom_range(0, 63), 2, 7, 11, $urandom_range(1, 127), $urandom_range(1, 127), ok);
        send_cmd(2, 4, 12, $urandom_range(0, 63), $urandom_range(0, 15), 5, 9, ok);
        for (int i = 0; i < 12; i++) begin
            gen_cmd(1'b1, t, leaf, self, pl, pp, ba, fs);
            send_cmd(t, leaf, self, pl, pp, ba, fs, ok);
        end
        wait_drain(to);
        checks++; if (to) begin errors++; $display("FAIL kinds_drain: got %0d pkts want %0d", obs_q.size(), exp_q.size()); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL kinds_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL kinds_pkt%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (pkt_count !== 16'(exp_pkts)) begin errors++; $display("FAIL kinds_cnt: got %0d want %0d", pkt_count, exp_pkts); end
    endtask

    task automatic test_illegal();
        bit ok;
        logic [15:0] cnt0;
        do_reset();
        out_ready = 1'b1;
        cnt0 = pkt_count;
        send_cmd(1, 1, 9, 0, 0, 0, 0, ok);
        send_cmd(0, 2, 3, 0, 0, 0, 0, ok);
        send_cmd(3, 3, 10, 0, 0, 0, 0, ok);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (err_seen != 3) begin errors++; $display("FAIL illegal_pulses: got %0d want 3", err_seen); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL illegal_pkts: got %0d want 0", obs_q.size()); end
        checks++; if (pkt_count !== cnt0) begin errors++; $display("FAIL illegal_cnt: got %0d want %0d", pkt_count, cnt0); end
    endtask

    task automatic test_backpressure_gap();
        bit ok, to;
        int t, leaf, self, pl, pp, ba, fs;
        logic [96:0] held;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            gen_cmd(1'b1, t, leaf, self, pl, pp, ba, fs);
            send_cmd(t, leaf, self, pl, pp, ba, fs, ok);
            checks++; if (!ok) begin errors++; $display("FAIL bp_accept%0d: got timeout want handshake", i); end
        end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b want 0", cmd_ready); end
        held = configure_out;
        checks++; if (held !== exp_q[0]) begin errors++; $display("FAIL bp_head: got %h want %h", held, exp_q[0]); end
        repeat (4) @(negedge clk);
        checks++; if (configure_out !== held) begin errors++; $display("FAIL bp_stable: got %h want %h", configure_out, held); end
        checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL bp_cnt_hold: got %0d want 0", pkt_count); end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain(to);
        for (int i = 0; i < 60 && g_obs_q.size() < 5; i++) @(posedge clk);
        #1;
        checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL bp_count: got %0d want 5", obs_q.size()); end
        checks++; if (g_obs_q.size() != 5) begin errors++; $display("FAIL gap_count: got %0d want 5", g_obs_q.size()); end
        for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_pkt%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
            if (i > 0) begin
                checks++;
                if (obs_cyc[i] - obs_cyc[i-1] != 1) begin errors++; $display("FAIL bp_spacing%0d: got %0d want 1", i, obs_cyc[i] - obs_cyc[i-1]); end
            end
        end
        for (int i = 0; i < 5 && i < g_obs_q.size(); i++) begin
            checks++;
            if (g_obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL gap_pkt%0d: got %h want %h", i, g_obs_q[i], exp_q[i]); end
            if (i > 0) begin
                checks++;
                if (g_obs_cyc[i] - g_obs_cyc[i-1] != 3) begin errors++; $display("FAIL gap_spacing%0d: got %0d want 3", i, g_obs_cyc[i] - g_obs_cyc[i-1]); end
            end
        end
        checks++; if (pkt_count !== 16'd5) begin errors++; $display("FAIL bp_cnt: got %0d want 5", pkt_count); end
        checks++; if (g_pkt_count !== 16'd5) begin errors++; $display("FAIL gap_cnt: got %0d want 5", g_pkt_count); end
    endtask

    task automatic test_random_traffic();
        bit ok, to, done;
        int t, leaf, self, pl, pp, ba, fs;
        do_reset();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    gen_cmd(($urandom_range(0, 3) != 0), t, leaf, self, pl, pp, ba, fs);
                    send_cmd(t, leaf, self, pl, pp, ba, fs, ok);
                    if ($urandom_range(0, 2) == 0) @(posedge clk);
                    #1;
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #2 out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain(to);
        checks++; if (to) begin errors++; $display("FAIL rand_drain: got %0d pkts want %0d", obs_q.size(), exp_q.size()); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_pkt%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (err_seen != exp_err) begin errors++; $display("FAIL rand_err: got %0d want %0d", err_seen, exp_err); end
        checks++; if (pkt_count !== 16'(exp_pkts)) begin errors++; $display("FAIL rand_cnt: got %0d want %0d", pkt_count, exp_pkts); end
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        do_reset();
        out_ready = 1'b0;
        send_cmd(2, 9, 13, 0, 0, 0, 0, ok);
        send_cmd(1, 8, 4, 1, 1, 0, 0, ok);
        repeat (2) @(negedge clk);
        checks++; if (configure_out[96] !== 1'b1) begin errors++; $display("FAIL mid_valid: got %b want 1", configure_out[96]); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (configure_out !== 97'd0) begin errors++; $display("FAIL mid_async_clear: got %h want 0", configure_out); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_low: got %b want 0", cmd_ready); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        obs_q.delete();
        repeat (8) @(posedge clk);
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", cmd_ready); end
        checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL mid_cnt: got %0d want 0", pkt_count); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mid_resend: got %0d pkts want 0", obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_out_bind_latency();
        test_kinds_stream();
        test_illegal();
        test_backpressure_gap();
        test_random_traffic();
        test_reset_mid_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
